// File: rtl/nibble_serial_alu_ctrl_pkg.sv
// Shared encodings for the nibble-serial ALU sequencer: request ops, ALU opcodes
// and FSM states.
package nibble_serial_alu_ctrl_pkg;

   localparam int unsigned NIBBLE_W = 4;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

endpackage

// File: rtl/nibble_serial_alu_ctrl.sv
// Multi-precision sequencer: feeds an external 4-bit ALU one nibble per cycle,
// LSB first, chaining the carry and assembling the W-bit result.
module nibble_serial_alu_ctrl
   import nibble_serial_alu_ctrl_pkg::*;
#(
   parameter int unsigned NIBBLES = 4,
   localparam int unsigned W = NIBBLE_W * NIBBLES
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [1:0]          in_op_i,
   input  logic [W-1:0]        in_a_i,
   input  logic [W-1:0]        in_b_i,
   input  logic                in_cin_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [W-1:0]        out_result_o,
   output logic                out_cout_o,
   output logic                out_zero_o,
   output logic [NIBBLE_W-1:0] alu_a_o,
   output logic [NIBBLE_W-1:0] alu_b_o,
   output logic [1:0]          alu_opcode_o,
   output logic                alu_cin_o,
   input  logic [NIBBLE_W-1:0] alu_result_i,
   input  logic                alu_cout_i
);

   localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

   state_e                              state_q, state_d;
   logic [NIBBLES-1:0][NIBBLE_W-1:0]    a_q, a_d;
   logic [NIBBLES-1:0][NIBBLE_W-1:0]    b_q, b_d;
   logic [NIBBLES-1:0][NIBBLE_W-1:0]    res_q, res_d;
   logic [1:0]                          op_q, op_d;
   logic [IdxW-1:0]                     idx_q, idx_d;
   logic                                carry_q, carry_d;
   logic                                zero_q, zero_d;
   logic                                arith;
   logic [NIBBLE_W-1:0]                 b_nib;

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      res_d        = res_q;
      op_d         = op_q;
      idx_d        = idx_q;
      carry_d      = carry_q;
      zero_d       = zero_q;
      in_ready_o   = 1'b0;
      alu_a_o      = '0;
      alu_b_o      = '0;
      alu_opcode_o = ALU_ADD;
      alu_cin_o    = 1'b0;
      arith        = (op_q == OP_ADD) || (op_q == OP_SUB);
      b_nib        = b_q[idx_q];

      unique case (state_q)
         IDLE: begin
            // Ready is gated by reset so nothing is offered while held in reset.
            in_ready_o = rst_n;
            if (in_valid_i) begin
               a_d     = in_a_i;
               b_d     = in_b_i;
               op_d    = in_op_i;
               idx_d   = '0;
               carry_d = (in_op_i == OP_ADD) ? in_cin_i : (in_op_i == OP_SUB);
               state_d = RUN;
            end
         end
         RUN: begin
            alu_a_o   = a_q[idx_q];
            alu_b_o   = (op_q == OP_SUB) ? ~b_nib : b_nib;
            alu_cin_o = arith & carry_q;
            unique case (op_q)
               OP_AND:  alu_opcode_o = ALU_AND;
               OP_OR:   alu_opcode_o = ALU_OR;
               default: alu_opcode_o = ALU_ADD;
            endcase
            res_d[idx_q] = alu_result_i;
            carry_d      = arith & alu_cout_i;
            if (idx_q == LastIdx) begin
               zero_d  = (res_d == '0);
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_valid_o  = (state_q == DONE);
   assign out_result_o = res_q;
   assign out_cout_o   = carry_q;
   assign out_zero_o   = zero_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         op_q    <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
      end
   end

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Directed bench for nibble_serial_alu_ctrl (NIBBLES = 4) with a behavioural
// 4-bit ALU attached to the alu_* ports.
module tb_nibble_serial_alu_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        in_cin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic        out_cout;
   logic        out_zero;
   logic [3:0]  alu_a;
   logic [3:0]  alu_b;
   logic [1:0]  alu_opcode;
   logic        alu_cin;
   logic [3:0]  alu_result;
   logic        alu_cout;

   int tests  = 0;
   int failed = 0;

   nibble_serial_alu_ctrl #(.NIBBLES(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_op_i      (in_op),
      .in_a_i       (in_a),
      .in_b_i       (in_b),
      .in_cin_i     (in_cin),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_result_o (out_result),
      .out_cout_o   (out_cout),
      .out_zero_o   (out_zero),
      .alu_a_o      (alu_a),
      .alu_b_o      (alu_b),
      .alu_opcode_o (alu_opcode),
      .alu_cin_o    (alu_cin),
      .alu_result_i (alu_result),
      .alu_cout_i   (alu_cout)
   );

   always_comb begin
      {alu_cout, alu_result} = 5'd0;
      case (alu_opcode)
         2'b00:   {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
         2'b10:   alu_result = alu_a & alu_b;
         2'b11:   alu_result = alu_a | alu_b;
         default: {alu_cout, alu_result} = 5'd0;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] res;
      logic        cout;
      logic        zero;
      logic [3:0]  cins;   // bit i = alu_cin during RUN cycle i
      logic [3:0]  b0;     // alu_b in RUN cycle 0
      logic [1:0]  opc;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one request and wait for out_valid; does not consume the result.
   task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, output int lat, output logic [3:0] cins,
                        output logic [3:0] b0, output logic [1:0] opc);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", 32'(n < 20), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_op    = ~op;
      in_a     = ~a;
      in_b     = ~b;
      in_cin   = ~cin;
      cins = '0;
      b0   = '0;
      opc  = '0;
      lat  = 0;
      while (!out_valid && lat < 20) begin
         if (lat < 4) cins[lat] = alu_cin;
         if (lat == 0) begin
            b0  = alu_b;
            opc = alu_opcode;
         end
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic finish_op(input string name);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({name, ".valid_drop"}, 32'(out_valid), 32'd0);
      chk({name, ".idle_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int          lat;
      logic [3:0]  cins;
      logic [3:0]  b0;
      logic [1:0]  opc;

      vecs[0] = '{2'b00, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 4'b1110, 4'hD, 2'b00};
      vecs[1] = '{2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b1110, 4'h1, 2'b00};
      vecs[2] = '{2'b01, 16'h5000, 16'h0001, 1'b0, 16'h4FFF, 1'b1, 1'b0, 4'b0001, 4'hE, 2'b00};
      vecs[3] = '{2'b01, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b0, 4'b0001, 4'hA, 2'b00};
      vecs[4] = '{2'b10, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 1'b0, 1'b0, 4'b0000, 4'hC, 2'b10};
      vecs[5] = '{2'b11, 16'hF0F0, 16'h3C3C, 1'b1, 16'hFCFC, 1'b0, 1'b0, 4'b0000, 4'hC, 2'b11};
      vecs[6] = '{2'b00, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b0, 4'b1111, 4'h0, 2'b00};
      vecs[7] = '{2'b01, 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b1, 4'b1111, 4'hA, 2'b00};
      vecs[8] = '{2'b10, 16'h0F0F, 16'hF0F0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'b0000, 4'h0, 2'b10};
      vecs[9] = '{2'b11, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 4'b0000, 4'h0, 2'b11};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = '0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      out_ready = 1'b0;

      // Reset state, including across a clock edge with in_valid raised.
      #3;
      in_valid = 1'b1;
      #10;
      chk("rst.in_ready", 32'(in_ready), 32'd0);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.out_result", 32'(out_result), 32'd0);
      chk("rst.cout_zero", {30'd0, out_cout, out_zero}, 32'd0);
      chk("rst.alu", {21'd0, alu_a, alu_b, alu_opcode, alu_cin}, 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // out_ready without out_valid is ignored.
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      out_ready = 1'b0;
      chk("idle.out_valid", 32'(out_valid), 32'd0);
      chk("idle.in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 10; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, lat, cins, b0, opc);
         chk($sformatf("v%0d.latency", i), 32'(lat), 32'd4);
         chk($sformatf("v%0d.result", i), 32'(out_result), 32'(vecs[i].res));
         chk($sformatf("v%0d.cout", i), 32'(out_cout), 32'(vecs[i].cout));
         chk($sformatf("v%0d.zero", i), 32'(out_zero), 32'(vecs[i].zero));
         chk($sformatf("v%0d.alu_cin_seq", i), 32'(cins), 32'(vecs[i].cins));
         chk($sformatf("v%0d.alu_b0", i), 32'(b0), 32'(vecs[i].b0));
         chk($sformatf("v%0d.alu_opcode", i), 32'(opc), 32'(vecs[i].opc));
         finish_op($sformatf("v%0d", i));
      end

      // Backpressure in DONE with a new request pending.
      do_op(2'b00, 16'h1111, 16'h2222, 1'b0, lat, cins, b0, opc);
      chk("hold.latency", 32'(lat), 32'd4);
      in_valid = 1'b1;
      in_op    = 2'b11;
      in_a     = 16'hAAAA;
      in_b     = 16'h5555;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("hold%0d.out", k), {out_valid, in_ready, out_cout, out_zero, out_result},
             {1'b1, 1'b0, 1'b0, 1'b0, 16'h3333});
         chk($sformatf("hold%0d.alu", k), {21'd0, alu_a, alu_b, alu_opcode, alu_cin}, 32'd0);
      end
      in_valid = 1'b0;
      finish_op("hold");
      do_op(2'b00, 16'h00FF, 16'h0001, 1'b0, lat, cins, b0, opc);
      chk("post_hold.latency", 32'(lat), 32'd4);
      chk("post_hold.result", 32'(out_result), 32'h0100);
      finish_op("post_hold");

      // Asynchronous reset in RUN at idx 2.
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = 2'b00;
      in_a     = 16'h0A00;
      in_b     = 16'h0B00;
      in_cin   = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort.alu_a_idx2", 32'(alu_a), 32'hA);
      #1 rst_n = 1'b0;
      #1;
      chk("abort.out_valid", 32'(out_valid), 32'd0);
      chk("abort.in_ready", 32'(in_ready), 32'd0);
      chk("abort.alu", {21'd0, alu_a, alu_b, alu_opcode, alu_cin}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("abort.no_valid", 32'(out_valid), 32'd0);
      end
      do_op(2'b00, 16'h0001, 16'h0001, 1'b0, lat, cins, b0, opc);
      chk("abort.after.latency", 32'(lat), 32'd4);
      chk("abort.after.result", 32'(out_result), 32'h0002);
      chk("abort.after.cout", 32'(out_cout), 32'd0);
      finish_op("abort.after");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/nibble_serial_alu_ctrl.md
Name: nibble_serial_alu_ctrl

Overview:
- Multi-precision sequencer for the 4-bit combinational ALU.
- Accepts one W-bit operation (W = 4*NIBBLES) over a valid/ready handshake.
- Drives the ALU one nibble per cycle, LSB first, chains the carry, and assembles the W-bit result.
- Sits directly upstream of the ALU (drives its operand, opcode and carry-in ports) and directly downstream of it (consumes its result and carry-out).

Parameters:
NIBBLES, 4, number of 4-bit slices per operation; W = 4*NIBBLES; legal range 1..16

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid & in_ready at a clk edge
in_op  input  2  00 ADD, 01 SUB, 10 AND, 11 OR
in_a  input  W  operand A
in_b  input  W  operand B
in_cin  input  1  carry-in; used for ADD only
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid & out_ready at a clk edge
out_result  output  W  assembled result
out_cout  output  1  final carry (ADD), not-borrow (SUB), 0 (AND/OR)
out_zero  output  1  1 when out_result == 0
alu_a  output  4  ALU operand a
alu_b  output  4  ALU operand b
alu_opcode  output  2  ALU opcode
alu_cin  output  1  ALU carry-in
alu_result  input  4  ALU result (combinational)
alu_cout  input  1  ALU carry-out (combinational)

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While rst_n = 0:
  - state = IDLE
  - all registers = 0
  - out_valid = 0, out_result = 0, out_cout = 0, out_zero = 0
  - in_ready = 0 (forced low)
  - alu_* = 0
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On accept: latch in_a, in_b, in_op; idx <= 0; carry <= in_cin (ADD), 1 (SUB), 0 (AND/OR); go to RUN.
- RUN:
  - in_ready = 0.
  - alu_a = A[4*idx+3:4*idx].
  - alu_b = B nibble (SUB: bitwise inverted B nibble).
  - alu_opcode = 00 for ADD/SUB, 10 for AND, 11 for OR.
  - alu_cin = carry for ADD/SUB, 0 for AND/OR.
  - Each edge: result nibble idx <= alu_result; carry <= alu_cout (ADD/SUB), 0 (AND/OR); idx <= idx+1.
  - On the edge where idx == NIBBLES-1: go to DONE.
- DONE:
  - out_valid = 1; out_result, out_cout, out_zero are held stable until the handshake.
  - On out_valid & out_ready: go to IDLE; out_valid drops on the next cycle.
- Latency: out_valid rises exactly NIBBLES edges after the accepting edge.
- Throughput: no overlap; minimum NIBBLES+2 cycles per op.
- Idle drive: outside RUN, alu_a, alu_b, alu_cin = 0 and alu_opcode = 00.
- Width rules:
  - SUB computes A + ~B + 1 mod 2^W; out_cout = 1 means A >= B (unsigned).
  - ADD computes A + B + in_cin; out_cout = bit W of the sum.
  - in_cin is ignored for SUB, AND and OR.
- Boundary conditions:
  - in_valid outside IDLE is ignored (in_ready = 0). The requester holds the request until accepted.
  - in_a, in_b and in_op changing after acceptance have no effect.
  - out_ready asserted without out_valid has no effect.
  - NIBBLES = 1: a single RUN cycle.
  - idx never wraps; it resets to 0 on every accept.
  - Reset asserted mid-RUN or in DONE aborts the operation. No out_valid is produced for it; the block restarts in IDLE.
- out_zero is registered together with the final nibble: computed from the full assembled result on the last RUN edge.

Decomposition:
- Shared package contents:
  - request op encodings: OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11
  - ALU opcode constants: ALU_ADD = 2'b00, ALU_AND = 2'b10, ALU_OR = 2'b11
  - state typedef {IDLE, RUN, DONE}
  - NIBBLE_W = 4
- No sub-module inside this block. The ALU is instantiated beside it by the parent and connected through the alu_* ports.
- Benches use a behavioural ALU model or the real ALU.

Test Plan (NIBBLES = 4, W = 16):
1. ADD 0x1234 + 0x0FCD, in_cin = 0 -> out_result 0x2201, out_cout 0, out_zero 0; out_valid exactly 4 edges after accept.
2. ADD 0xFFFF + 0x0001, in_cin = 0 -> out_result 0x0000, out_cout 1, out_zero 1; alu_cin sequence 0,1,1,1 across the four RUN cycles.
3. SUB 0x5000 - 0x0001 -> out_result 0x4FFF, out_cout 1; then SUB 0x0003 - 0x0005 -> out_result 0xFFFE, out_cout 0; alu_b nibble 0 = 0xA on the second op.
4. AND 0xF0F0 & 0x3C3C with in_cin = 1 -> out_result 0x3030, out_cout 0, alu_cin 0 every cycle; OR on the same operands -> 0xFCFC.
5. Hold out_ready = 0 for 5 cycles in DONE while in_valid = 1 with new operands -> out_valid and outputs stable, in_ready 0; after out_ready, IDLE; the next op is accepted and completes correctly.
6. Drop rst_n asynchronously during RUN idx = 2 -> out_valid, in_ready and alu_* go 0 immediately; after release, ADD 0x0001 + 0x0001 -> 0x0002 with correct latency.
